hls_deadlock_monitor_multi: RTL and testbench

Parametrised deadlock monitor for one HLS-generated module instance in the overlay datapath. It combines N AXI-Stream block signals and N sub-instance block/idle signals into a qualified `block` flag. The flag asserts only after a programmable number of consecutive blocked cycles and can optionally latch until cleared. It also reports which source blocked first and counts block events; it sits beside each monitored instance and feeds the overlay's top-level deadlock aggregation.

---
 rtl/hls_deadlock_monitor_multi_if.sv | 39 +++
 rtl/hls_deadlock_monitor_multi.sv | 140 ++++++++++++++
 tb/tb_hls_deadlock_monitor_multi.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/hls_deadlock_monitor_multi_if.sv
// Block/idle inputs and qualified deadlock status
// for one monitored HLS instance.
interface hls_deadlock_monitor_multi_if #(
  parameter int N_AXIS = 3,
  parameter int N_SUB  = 1
);
  localparam int FW = $clog2(N_AXIS + N_SUB + 1);

  logic [N_AXIS-1:0] axis_block_sigs;
  logic [N_SUB-1:0]  inst_block_sigs;
  logic [N_SUB-1:0]  inst_idle_sigs;
  logic              clear;
  logic              block;
  logic              first_src_valid;
  logic [FW-1:0]     first_src;
  logic [15:0]       block_events;

  modport master (
    output axis_block_sigs,
    output inst_block_sigs,
    output inst_idle_sigs,
    output clear,
    input  block,
    input  first_src_valid,
    input  first_src,
    input  block_events
  );

  modport slave (
    input  axis_block_sigs,
    input  inst_block_sigs,
    input  inst_idle_sigs,
    input  clear,
    output block,
    output first_src_valid,
    output first_src,
    output block_events
  );
endinterface

// File: rtl/hls_deadlock_monitor_multi.sv
// Deadlock qualifier: raw block must persist THRESHOLD
// cycles; records first blocking source and entry count.
module hls_deadlock_monitor_multi #(
  parameter int              N_AXIS    = 3,
  parameter logic [N_AXIS-1:0] AXIS_MASK = {N_AXIS{1'b1}},
  parameter int              N_SUB     = 1,
  parameter int              SUB_MODE  = 0,
  parameter int              THRESHOLD = 1,
  parameter int              STICKY    = 0
) (
  input  logic clock,
  input  logic reset,
  hls_deadlock_monitor_multi_if.slave bus
);
  localparam int NS = N_AXIS + N_SUB;
  localparam int FW = $clog2(NS + 1);
  localparam int CW = $clog2(THRESHOLD + 1);
  localparam logic [CW-1:0] THR_M1 = CW'(THRESHOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    BLOCKED
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fsv_q, fsv_d;
  logic [FW-1:0] fs_q, fs_d;
  logic [15:0]   ev_q, ev_d;

  logic [N_AXIS-1:0] axis_hit;
  logic              axis_raw;
  logic              sub_raw;
  logic              raw;
  logic [NS-1:0]     src;
  logic [FW-1:0]     pick;
  logic              enter;

  // Raw blocked condition from streams and sub-instances
  always_comb begin
    axis_hit = bus.axis_block_sigs & AXIS_MASK;
    axis_raw = |axis_hit;
    if (SUB_MODE == 1) begin
      sub_raw = (&(bus.inst_block_sigs | bus.inst_idle_sigs))
              & (|bus.inst_block_sigs);
    end else begin
      sub_raw = |bus.inst_block_sigs;
    end
    raw = axis_raw | sub_raw;
  end

  // Lowest-index source blocked this cycle; idle never qualifies
  always_comb begin
    src  = {bus.inst_block_sigs, axis_hit};
    pick = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (src[i]) pick = FW'(i);
    end
  end

  // Next-state, qualification counter and capture logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fsv_d   = fsv_q;
    fs_d    = fs_q;
    ev_d    = ev_q;
    enter   = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      fsv_d   = 1'b0;
      fs_d    = '0;
      ev_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (raw) begin
            if (THRESHOLD == 1) begin
              state_d = BLOCKED;
              enter   = 1'b1;
            end else begin
              state_d = PENDING;
              cnt_d   = CW'(1);
            end
          end
        end
        PENDING: begin
          if (!raw) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == THR_M1) begin
            state_d = BLOCKED;
            cnt_d   = '0;
            enter   = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        BLOCKED: begin
          if (!raw && STICKY == 0) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      if (enter) begin
        if (ev_q != 16'hFFFF) ev_d = ev_q + 16'd1;
        if (!fsv_q) begin
          fsv_d = 1'b1;
          fs_d  = pick;
        end
      end
    end
  end

  // State and status registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fsv_q   <= 1'b0;
      fs_q    <= '0;
      ev_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fsv_q   <= fsv_d;
      fs_q    <= fs_d;
      ev_q    <= ev_d;
    end
  end

  assign bus.block           = (state_q == BLOCKED);
  assign bus.first_src_valid = fsv_q;
  assign bus.first_src       = fs_q;
  assign bus.block_events    = ev_q;
endmodule

// File: tb/tb_hls_deadlock_monitor_multi.sv
// Directed checks of deadlock qualification across
// several parameter sets.
module tb_hls_deadlock_monitor_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hls_deadlock_monitor_multi_if #(.N_AXIS(3), .N_SUB(1)) if0 ();
  hls_deadlock_monitor_multi_if #(.N_AXIS(3), .N_SUB(1)) if1 ();
  hls_deadlock_monitor_multi_if #(.N_AXIS(3), .N_SUB(1)) if2 ();
  hls_deadlock_monitor_multi_if #(.N_AXIS(3), .N_SUB(3)) if3 ();
  hls_deadlock_monitor_multi_if #(.N_AXIS(3), .N_SUB(1)) if4 ();
  hls_deadlock_monitor_multi_if #(.N_AXIS(3), .N_SUB(1)) if5 ();

  hls_deadlock_monitor_multi u0 (
    .clock(clk), .reset(rst), .bus(if0.slave));
  hls_deadlock_monitor_multi #(.THRESHOLD(4)) u1 (
    .clock(clk), .reset(rst), .bus(if1.slave));
  hls_deadlock_monitor_multi #(.AXIS_MASK(3'b110)) u2 (
    .clock(clk), .reset(rst), .bus(if2.slave));
  hls_deadlock_monitor_multi #(.N_SUB(3), .SUB_MODE(1)) u3 (
    .clock(clk), .reset(rst), .bus(if3.slave));
  hls_deadlock_monitor_multi #(.STICKY(1)) u4 (
    .clock(clk), .reset(rst), .bus(if4.slave));
  hls_deadlock_monitor_multi #(.THRESHOLD(8)) u5 (
    .clock(clk), .reset(rst), .bus(if5.slave));

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    if0.axis_block_sigs = '0; if0.inst_block_sigs = '0;
    if0.inst_idle_sigs = '0;  if0.clear = 1'b0;
    if1.axis_block_sigs = '0; if1.inst_block_sigs = '0;
    if1.inst_idle_sigs = '0;  if1.clear = 1'b0;
    if2.axis_block_sigs = '0; if2.inst_block_sigs = '0;
    if2.inst_idle_sigs = '0;  if2.clear = 1'b0;
    if3.axis_block_sigs = '0; if3.inst_block_sigs = '0;
    if3.inst_idle_sigs = '0;  if3.clear = 1'b0;
    if4.axis_block_sigs = '0; if4.inst_block_sigs = '0;
    if4.inst_idle_sigs = '0;  if4.clear = 1'b0;
    if5.axis_block_sigs = '0; if5.inst_block_sigs = '0;
    if5.inst_idle_sigs = '0;  if5.clear = 1'b0;
    tick(3);
    rst = 1'b0;
    tick();

    chk("rst_block", 32'(if0.block), 0);
    chk("rst_fsv", 32'(if0.first_src_valid), 0);
    chk("rst_fs", 32'(if0.first_src), 0);
    chk("rst_ev", 32'(if0.block_events), 0);

    // T=1: one raw cycle -> one block cycle
    if0.axis_block_sigs = 3'b010;
    tick();
    chk("t1_block", 32'(if0.block), 1);
    chk("t1_fs", 32'(if0.first_src), 1);
    chk("t1_fsv", 32'(if0.first_src_valid), 1);
    chk("t1_ev", 32'(if0.block_events), 1);
    if0.axis_block_sigs = 3'b000;
    tick();
    chk("t1_drop", 32'(if0.block), 0);
    if0.inst_block_sigs = 1'b1;
    tick();
    chk("t1_sub_block", 32'(if0.block), 1);
    chk("t1_ev2", 32'(if0.block_events), 2);
    chk("t1_fs_keep", 32'(if0.first_src), 1);
    if0.inst_block_sigs = 1'b0;
    if0.axis_block_sigs = 3'b001;
    if0.clear = 1'b1;
    tick();
    chk("clr_block", 32'(if0.block), 0);
    chk("clr_ev", 32'(if0.block_events), 0);
    chk("clr_fsv", 32'(if0.first_src_valid), 0);
    if0.clear = 1'b0;
    if0.axis_block_sigs = 3'b100;
    tick();
    chk("clr_reblock", 32'(if0.block), 1);
    chk("clr_fs", 32'(if0.first_src), 2);
    chk("clr_ev1", 32'(if0.block_events), 1);
    if0.axis_block_sigs = 3'b000;
    tick();

    // T=4: short burst is rejected
    if1.axis_block_sigs = 3'b001;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_burst1", 32'(if1.block), 0);
    end
    if1.axis_block_sigs = 3'b000;
    tick();
    if1.axis_block_sigs = 3'b001;
    tick(3);
    chk("t4_e2", 32'(if1.block), 0);
    tick();
    chk("t4_e3", 32'(if1.block), 1);
    chk("t4_ev", 32'(if1.block_events), 1);
    chk("t4_fs", 32'(if1.first_src), 0);
    if1.axis_block_sigs = 3'b000;
    tick();
    chk("t4_drop", 32'(if1.block), 0);

    // Masked stream never blocks
    if2.axis_block_sigs = 3'b001;
    tick(10);
    chk("mask_block", 32'(if2.block), 0);
    chk("mask_fsv", 32'(if2.first_src_valid), 0);
    if2.axis_block_sigs = 3'b011;
    tick();
    chk("mask_on", 32'(if2.block), 1);
    chk("mask_fs", 32'(if2.first_src), 1);
    if2.axis_block_sigs = 3'b000;
    tick();

    // Parallel sub mode
    if3.inst_block_sigs = 3'b011;
    if3.inst_idle_sigs  = 3'b000;
    tick(3);
    chk("par_noidle", 32'(if3.block), 0);
    if3.inst_idle_sigs = 3'b100;
    tick();
    chk("par_block", 32'(if3.block), 1);
    chk("par_fs", 32'(if3.first_src), 3);
    if3.inst_block_sigs = 3'b000;
    if3.inst_idle_sigs  = 3'b111;
    tick();
    chk("par_allidle", 32'(if3.block), 0);

    // Sticky hold then clear
    if4.axis_block_sigs = 3'b001;
    tick();
    if4.axis_block_sigs = 3'b000;
    for (int i = 0; i < 20; i++) begin
      chk("sticky_hold", 32'(if4.block), 1);
      tick();
    end
    if4.clear = 1'b1;
    tick();
    chk("sticky_clr", 32'(if4.block), 0);
    chk("sticky_ev", 32'(if4.block_events), 0);
    chk("sticky_fsv", 32'(if4.first_src_valid), 0);
    if4.clear = 1'b0;
    tick();
    chk("sticky_idle", 32'(if4.block), 0);

    // Async reset mid-PENDING discards count
    if0.axis_block_sigs = 3'b001;
    if5.axis_block_sigs = 3'b001;
    tick(5);
    chk("r8_pend", 32'(if5.block), 0);
    chk("r8_u0_blk", 32'(if0.block), 1);
    #2 rst = 1'b1;
    #1;
    chk("r8_async_blk", 32'(if0.block), 0);
    chk("r8_async_ev", 32'(if0.block_events), 0);
    chk("r8_async_fsv", 32'(if0.first_src_valid), 0);
    chk("r8_u5_blk", 32'(if5.block), 0);
    tick();
    rst = 1'b0;
    tick(7);
    chk("r8_e6", 32'(if5.block), 0);
    tick();
    chk("r8_e7", 32'(if5.block), 1);
    chk("r8_ev", 32'(if5.block_events), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
